// File: rtl/shift_counter_pkg.sv
//------------------------------------------------------------------------------
// Module  : shift_counter_pkg
// Brief   : Mode/direction encodings and home-state helper for shift_counter_gen.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package shift_counter_pkg;

  localparam logic c_MODE_JOHNSON = 1'b0;
  localparam logic c_MODE_RING    = 1'b1;
  localparam logic c_DIR_LEFT     = 1'b0;
  localparam logic c_DIR_RIGHT    = 1'b1;

  localparam int   c_MAX_W        = 64;

  // Johnson rests at all-zeros, ring at a single one in bit 0.
  function automatic logic [c_MAX_W-1:0] home_state(input logic mode, input int width);
    logic [c_MAX_W-1:0] r;
    r = '0;
    if (mode == c_MODE_RING && width > 0) r[0] = 1'b1;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_counter_legal.sv
//------------------------------------------------------------------------------
// Module  : shift_counter_legal
// Brief   : Combinational legality check of a Johnson or one-hot ring code.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module shift_counter_legal
  import shift_counter_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] q,
  input  logic             mode,
  output logic             valid
);

  localparam int c_CW = $clog2(WIDTH + 1);

  logic [c_CW-1:0] w_edges;
  logic [c_CW-1:0] w_ones;

  // Johnson codes have at most one 0/1 boundary; ring codes exactly one set bit.
  always_comb begin
    w_edges = '0;
    w_ones  = '0;
    for (int i = 0; i < WIDTH - 1; i++)
      w_edges = w_edges + {{(c_CW-1){1'b0}}, q[i] ^ q[i+1]};
    for (int i = 0; i < WIDTH; i++)
      w_ones = w_ones + {{(c_CW-1){1'b0}}, q[i]};
  end

  assign valid = (mode == c_MODE_RING) ? (w_ones == c_CW'(1)) : (w_edges <= c_CW'(1));

endmodule

`default_nettype wire

// File: rtl/shift_counter_gen.sv
//------------------------------------------------------------------------------
// Module  : shift_counter_gen
// Brief   : Johnson / one-hot ring shift counter with load, direction, wrap pulse
//           and legality flag. Optional macro SHIFT_COUNTER_SELF_CORRECT_EN makes
//           an enabled step from an illegal code jump to the home state.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module shift_counter_gen
  import shift_counter_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             valid
);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic             r_mode_q;

  logic [WIDTH-1:0] w_home;
  logic [WIDTH-1:0] w_next;
  logic             w_valid;
  logic             w_fb;

  assign w_home = WIDTH'(home_state(mode, WIDTH));

  // Feedback bit is the outgoing end bit, inverted for the Johnson twist.
  always_comb begin
    w_fb   = (dir == c_DIR_LEFT) ? r_q[WIDTH-1] : r_q[0];
    w_fb   = (mode == c_MODE_RING) ? w_fb : ~w_fb;
    w_next = (dir == c_DIR_LEFT) ? {r_q[WIDTH-2:0], w_fb} : {w_fb, r_q[WIDTH-1:1]};
  end

  shift_counter_legal #(
    .WIDTH (WIDTH)
  ) u_legal (
    .q     (r_q),
    .mode  (mode),
    .valid (w_valid)
  );

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      r_q      <= w_home;
      r_wrap   <= 1'b0;
      r_mode_q <= mode;
    end else if (load) begin
      r_q      <= load_val;
      r_wrap   <= 1'b0;
      r_mode_q <= mode;
    end else if (mode != r_mode_q) begin
      r_q      <= w_home;
      r_wrap   <= 1'b0;
      r_mode_q <= mode;
    end else if (en) begin
`ifdef SHIFT_COUNTER_SELF_CORRECT_EN
      if (!w_valid) begin
        r_q    <= w_home;
        r_wrap <= 1'b1;
      end else begin
        r_q    <= w_next;
        r_wrap <= (w_next == w_home);
      end
`else
      r_q    <= w_next;
      r_wrap <= (w_next == w_home);
`endif
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign q     = r_q;
  assign wrap  = r_wrap;
  assign valid = w_valid;

endmodule

`default_nettype wire
